cfg_apb_regbank: RTL and testbench



---
 rtl/cfg_apb_regbank_pkg.sv | 67 ++++++
 rtl/cfg_apb_regbank_if.sv | 29 ++
 rtl/cfg_apb_regbank_apb3_slave_fsm.sv | 62 ++++++
 rtl/cfg_apb_regbank.sv | 139 +++++++++++++
 tb/tb_cfg_apb_regbank.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_apb_regbank_pkg.sv
// rtl/cfg_apb_regbank_pkg.sv - register map constants and address decode for the config register bank
//
// Purpose: shared register offsets, ID layout, CTRL bit positions and the
//          address decoder used by cfg_apb_regbank.
// Ports:   none (package).
package cfg_regbank_pkg;

  // Byte offsets of the fixed registers; CFG[i] lives at OFF_CFG_BASE + 4*i.
  localparam int unsigned OFF_CTRL     = 0;
  localparam int unsigned OFF_STATUS   = 4;
  localparam int unsigned OFF_IRQ_EN   = 8;
  localparam int unsigned OFF_ID       = 12;
  localparam int unsigned OFF_CFG_BASE = 16;

  // ID layout: unit count in the upper half-word, config count in the lower.
  localparam int unsigned ID_UNITS_LSB = 16;
  localparam int unsigned ID_CFG_LSB   = 0;

  // CTRL: start bits begin at bit 0; soft reset is the MSB of the data word.
  localparam int unsigned CTRL_START_LSB = 0;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_STATUS = 3'd1,
    REG_IRQ_EN = 3'd2,
    REG_ID     = 3'd3,
    REG_CFG    = 3'd4,
    REG_NONE   = 3'd5
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e    sel;
    logic [15:0] cfg_idx;
  } reg_dec_t;

  // Misaligned addresses and anything past the last CFG word decode to REG_NONE.
  function automatic reg_dec_t decode_addr(input logic [31:0] addr, input int unsigned num_cfg);
    reg_dec_t    d;
    logic [29:0] word;
    d.sel     = REG_NONE;
    d.cfg_idx = '0;
    word      = addr[31:2];
    if (addr[1:0] == 2'b00) begin
      if (word < 30'd4) begin
        case (word[1:0])
          2'd0:    d.sel = REG_CTRL;
          2'd1:    d.sel = REG_STATUS;
          2'd2:    d.sel = REG_IRQ_EN;
          default: d.sel = REG_ID;
        endcase
      end else if ((32'(word) - 32'd4) < num_cfg) begin
        d.sel     = REG_CFG;
        d.cfg_idx = 16'(word - 30'd4);
      end
    end
    return d;
  endfunction

  function automatic logic [31:0] id_word(input int unsigned num_units, input int unsigned num_cfg);
    logic [31:0] id;
    id = '0;
    id[ID_UNITS_LSB +: 16] = num_units[15:0];
    id[ID_CFG_LSB   +: 16] = num_cfg[15:0];
    return id;
  endfunction

endpackage

// File: rtl/cfg_apb_regbank_if.sv
// rtl/cfg_apb_regbank_if.sv - APB3 bus bundle for the config register bank
//
// Purpose: groups the APB3 request/response signals.
// Signals: PSEL/PENABLE/PWRITE control, PADDR byte address, PWDATA write data,
//          PRDATA read data, PREADY ready, PSLVERR error.
// Modports: master (host side), slave (register bank side).
interface cfg_apb_regbank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/cfg_apb_regbank_apb3_slave_fsm.sv
// rtl/cfg_apb_regbank_apb3_slave_fsm.sv - two-state APB3 slave handshake with zero wait states
//
// Purpose: tracks IDLE/ACCESS, registers PREADY/PSLVERR at the setup edge and
//          qualifies the write strobe for the closing edge.
// Ports:   PCLK, PRESETn (async active-low); psel/penable/pwrite/paddr from the bus;
//          setup_err computed by the bank during the setup phase;
//          wr_en (closing-edge write strobe), rd_en (setup-edge read capture),
//          addr_q (address latched at setup), pready, pslverr.
module apb3_slave_fsm #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  setup_err,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr_q,
  output logic                  pready,
  output logic                  pslverr
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0] state;
  logic       setup_phase;

  assign setup_phase = (state == IDLE) && psel && !penable;

  // The read mux is sampled on the setup edge so PRDATA is valid with PREADY.
  assign rd_en = setup_phase && !pwrite;
  // pslverr still holds the error flagged at setup, which suppresses the write.
  assign wr_en = (state == ACCESS) && psel && penable && pwrite && !pslverr;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup_phase) begin
            state   <= ACCESS;
            pready  <= 1'b1;
            pslverr <= setup_err;
            addr_q  <= paddr;
          end
        end
        default: begin
          state   <= IDLE;
          pready  <= 1'b0;
          pslverr <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/cfg_apb_regbank.sv
// rtl/cfg_apb_regbank.sv - APB3 double-buffered config and multi-unit start/done register bank
//
// Purpose: staged CFG words are copied to cfg_active on a CTRL start, so the host
//          can prepare the next job while units run.
// Ports:   PCLK, PRESETn (async active-low); apb (APB3 slave bundle);
//          cfg_active (committed words, word i at [i*DATA_WIDTH +: DATA_WIDTH]);
//          start (per-unit pulse), pe_reset (soft-reset pulse), busy (per unit),
//          done (per-unit completion pulse in), irq (registered interrupt).
module cfg_apb_regbank
  import cfg_regbank_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CFG    = 16,
  parameter int NUM_UNITS  = 4
) (
  input  logic                            PCLK,
  input  logic                            PRESETn,
  cfg_apb_regbank_if.slave                apb,
  output logic [NUM_CFG*DATA_WIDTH-1:0]   cfg_active,
  output logic [NUM_UNITS-1:0]            start,
  output logic                            pe_reset,
  output logic [NUM_UNITS-1:0]            busy,
  input  logic [NUM_UNITS-1:0]            done,
  output logic                            irq
);
  logic                  wr_en;
  logic                  rd_en;
  logic                  setup_err;
  logic                  start_conflict;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [DATA_WIDTH-1:0] rd_data;
  reg_dec_t              setup_dec;
  reg_dec_t              wr_dec;
  logic [NUM_UNITS-1:0]  wr_start;
  logic [NUM_UNITS-1:0]  w1c;
  logic [NUM_UNITS-1:0]  status;
  logic [NUM_UNITS-1:0]  irq_en;
  logic [DATA_WIDTH-1:0] cfg_staged [NUM_CFG];
  logic [DATA_WIDTH-1:0] cfg_act    [NUM_CFG];

  assign setup_dec = decode_addr(32'(apb.PADDR), NUM_CFG);
  assign wr_dec    = decode_addr(32'(addr_q), NUM_CFG);

  // Restarting a running unit is refused as a whole, including its commit.
  assign start_conflict = apb.PWRITE && (setup_dec.sel == REG_CTRL) &&
                          |(apb.PWDATA[CTRL_START_LSB +: NUM_UNITS] & busy);
  assign setup_err = (setup_dec.sel == REG_NONE) ||
                     (apb.PWRITE && (setup_dec.sel == REG_ID)) ||
                     start_conflict;

  apb3_slave_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_fsm (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .psel      (apb.PSEL),
    .penable   (apb.PENABLE),
    .pwrite    (apb.PWRITE),
    .paddr     (apb.PADDR),
    .setup_err (setup_err),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr_q    (addr_q),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  assign apb.PREADY  = pready;
  assign apb.PSLVERR = pslverr;
  assign apb.PRDATA  = prdata_q;

  assign wr_start = (wr_en && (wr_dec.sel == REG_CTRL)) ? apb.PWDATA[CTRL_START_LSB +: NUM_UNITS] : '0;
  assign w1c      = (wr_en && (wr_dec.sel == REG_STATUS)) ? apb.PWDATA[NUM_UNITS-1:0] : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        cfg_staged[i] <= '0;
        cfg_act[i]    <= '0;
      end
    end else begin
      if (wr_en && (wr_dec.sel == REG_CFG)) begin
        for (int i = 0; i < NUM_CFG; i++) begin
          if (wr_dec.cfg_idx == 16'(i)) cfg_staged[i] <= apb.PWDATA;
        end
      end
      // Commit uses the staged words as they stood before this edge.
      if (|wr_start) begin
        for (int i = 0; i < NUM_CFG; i++) cfg_act[i] <= cfg_staged[i];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      start    <= '0;
      pe_reset <= 1'b0;
      busy     <= '0;
      status   <= '0;
      irq_en   <= '0;
      irq      <= 1'b0;
    end else begin
      start    <= wr_start;
      pe_reset <= wr_en && (wr_dec.sel == REG_CTRL) && apb.PWDATA[DATA_WIDTH-1];
      busy     <= (busy & ~done) | wr_start;
      // OR-ing done after the clear lets a coincident completion survive W1C.
      status   <= (status & ~w1c) | done;
      if (wr_en && (wr_dec.sel == REG_IRQ_EN)) irq_en <= apb.PWDATA[NUM_UNITS-1:0];
      irq      <= |(status & irq_en);
    end
  end

  always_comb begin
    rd_data = '0;
    case (setup_dec.sel)
      REG_CTRL:   rd_data = DATA_WIDTH'(busy);
      REG_STATUS: rd_data = DATA_WIDTH'(status);
      REG_IRQ_EN: rd_data = DATA_WIDTH'(irq_en);
      REG_ID:     rd_data = DATA_WIDTH'(id_word(NUM_UNITS, NUM_CFG));
      REG_CFG: begin
        for (int i = 0; i < NUM_CFG; i++) begin
          if (setup_dec.cfg_idx == 16'(i)) rd_data = cfg_staged[i];
        end
      end
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) prdata_q <= '0;
    else if (rd_en) prdata_q <= rd_data;
  end

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
    assign cfg_active[g*DATA_WIDTH +: DATA_WIDTH] = cfg_act[g];
  end
endmodule

// File: tb/tb_cfg_apb_regbank.sv
// tb/tb_cfg_apb_regbank.sv - self-checking bench for cfg_apb_regbank
module tb_cfg_apb_regbank;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NC = 16;
  localparam int NU = 4;

  logic PCLK = 1'b0;
  logic PRESETn;
  logic [NC*DW-1:0] cfg_active;
  logic [NU-1:0]    start, busy, done;
  logic             pe_reset, irq;

  cfg_apb_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  cfg_apb_regbank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CFG(NC), .NUM_UNITS(NU)) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .apb        (apb),
    .cfg_active (cfg_active),
    .start      (start),
    .pe_reset   (pe_reset),
    .busy       (busy),
    .done       (done),
    .irq        (irq)
  );

  always #5 PCLK = ~PCLK;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model state
  logic [DW-1:0] m_stage  [NC];
  logic [DW-1:0] m_active [NC];
  logic [NU-1:0] m_busy, m_status, m_irq_en, m_start;
  logic          m_pe, m_irq;
  logic [DW-1:0] m_prdata;
  logic          pend_valid;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;
  logic          check_en, rand_en;
  logic [NU-1:0] done_req;

  logic [NU-1:0] mw_go, mw_clr;
  logic          mw_pe, mw_ien, mw_cfg;
  int            mw_idx;

  // Effect of the accepted write closing at the coming edge.
  always_comb begin
    mw_go  = '0;
    mw_clr = '0;
    mw_pe  = 1'b0;
    mw_ien = 1'b0;
    mw_cfg = 1'b0;
    mw_idx = int'(pend_addr) / 4 - 4;
    if (pend_valid) begin
      case (int'(pend_addr) / 4)
        0: begin mw_go = pend_data[NU-1:0]; mw_pe = pend_data[DW-1]; end
        1: mw_clr = pend_data[NU-1:0];
        2: mw_ien = 1'b1;
        default: mw_cfg = 1'b1;
      endcase
    end
  end

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NC; i++) begin
        m_stage[i]  <= '0;
        m_active[i] <= '0;
      end
      m_busy <= '0; m_status <= '0; m_irq_en <= '0; m_start <= '0; m_pe <= 1'b0; m_irq <= 1'b0;
    end else begin
      m_busy   <= (m_busy & ~done) | mw_go;
      m_start  <= mw_go;
      m_pe     <= mw_pe;
      if (mw_go != '0) for (int i = 0; i < NC; i++) m_active[i] <= m_stage[i];
      m_status <= (m_status & ~mw_clr) | done;
      if (mw_ien) m_irq_en <= pend_data[NU-1:0];
      if (mw_cfg) m_stage[mw_idx] <= pend_data;
      m_irq    <= |(m_status & m_irq_en);
    end
  end

  always @(negedge PCLK) begin
    if (check_en) begin
      chk("busy", DW'(busy), DW'(m_busy));
      chk("start", DW'(start), DW'(m_start));
      chk("pe_reset", DW'(pe_reset), DW'(m_pe));
      chk("irq", DW'(irq), DW'(m_irq));
      chk("prdata", apb.PRDATA, m_prdata);
      for (int i = 0; i < NC; i++) chk("cfg_active", cfg_active[i*DW +: DW], m_active[i]);
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
    if (rand_en) done = ($urandom_range(0, 5) == 0) ? NU'($urandom) : '0;
    else         done = done_req;
    done_req = '0;
  endtask

  task automatic model_resp(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            output logic err, output logic [DW-1:0] rd);
    int w;
    w   = int'(a) / 4;
    err = 1'b0;
    rd  = '0;
    if (a[1:0] != 2'b00 || w >= 4 + NC) err = 1'b1;
    else if (wr) begin
      if (w == 3) err = 1'b1;
      else if (w == 0 && (wd[NU-1:0] & m_busy) != '0) err = 1'b1;
    end else begin
      case (w)
        0: rd = DW'(m_busy);
        1: rd = DW'(m_status);
        2: rd = DW'(m_irq_en);
        3: rd = DW'((NU << 16) | NC);
        default: rd = m_stage[w-4];
      endcase
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          output logic [DW-1:0] rd_act, output logic err_act);
    logic          e;
    logic [DW-1:0] r;
    model_resp(wr, a, wd, e, r);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr; apb.PADDR = a; apb.PWDATA = wd;
    tick();
    chk("pready_setup", DW'(apb.PREADY), DW'(1));
    chk("pslverr", DW'(apb.PSLVERR), DW'(e));
    if (!wr) begin
      m_prdata = r;
      chk("read_data", apb.PRDATA, r);
    end
    rd_act  = apb.PRDATA;
    err_act = apb.PSLVERR;
    apb.PENABLE = 1'b1;
    pend_valid  = wr && !e;
    pend_addr   = a;
    pend_data   = wd;
    tick();
    chk("pready_close", DW'(apb.PREADY), DW'(0));
    pend_valid  = 1'b0;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pready"}, DW'(apb.PREADY), '0);
    chk({tag, "_pslverr"}, DW'(apb.PSLVERR), '0);
    chk({tag, "_prdata"}, apb.PRDATA, '0);
    chk({tag, "_start"}, DW'(start), '0);
    chk({tag, "_pe_reset"}, DW'(pe_reset), '0);
    chk({tag, "_busy"}, DW'(busy), '0);
    chk({tag, "_irq"}, DW'(irq), '0);
    chk({tag, "_cfg_active"}, DW'(|cfg_active), '0);
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          er;
    logic [DW-1:0] wd;
    logic [AW-1:0] a;
    int            op;

    PRESETn = 1'b0;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
    done = '0; done_req = '0; check_en = 1'b0; rand_en = 1'b0;
    pend_valid = 1'b0; pend_addr = '0; pend_data = '0; m_prdata = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    check_en = 1'b1;
    PRESETn  = 1'b1;
    tick();

    apb_xfer(1'b0, 8'h0C, '0, rd, er);
    chk("id_value", rd, 32'h0004_0010);
    chk("id_err", DW'(er), '0);

    apb_xfer(1'b1, 8'h1C, 32'hDEAD_BEEF, rd, er);
    apb_xfer(1'b0, 8'h1C, '0, rd, er);
    chk("cfg3_readback", rd, 32'hDEAD_BEEF);
    chk("cfg3_not_committed", cfg_active[3*DW +: DW], '0);
    apb_xfer(1'b1, 8'h00, 32'h1, rd, er);
    chk("start_u0", DW'(start), 32'h1);
    chk("busy_u0", DW'(busy), 32'h1);
    chk("cfg3_committed", cfg_active[3*DW +: DW], 32'hDEAD_BEEF);

    apb_xfer(1'b1, 8'h1C, 32'h1234, rd, er);
    apb_xfer(1'b1, 8'h00, 32'h1, rd, er);
    chk("restart_busy_err", DW'(er), 32'h1);
    chk("restart_no_start", DW'(start), '0);
    chk("restart_cfg_kept", cfg_active[3*DW +: DW], 32'hDEAD_BEEF);
    apb_xfer(1'b1, 8'h00, 32'h2, rd, er);
    chk("start_u1", DW'(start), 32'h2);
    chk("cfg3_recommit", cfg_active[3*DW +: DW], 32'h1234);

    apb_xfer(1'b1, 8'h08, 32'h2, rd, er);
    done_req = 4'b0010;
    tick();
    tick();
    chk("irq_lag", DW'(irq), '0);
    chk("busy_after_done1", DW'(busy), 32'h1);
    tick();
    chk("irq_set", DW'(irq), 32'h1);
    apb_xfer(1'b0, 8'h04, '0, rd, er);
    chk("status_done1", rd, 32'h2);
    done_req = 4'b0010;
    apb_xfer(1'b1, 8'h04, 32'h2, rd, er);
    apb_xfer(1'b0, 8'h04, '0, rd, er);
    chk("status_set_wins", rd, 32'h2);

    apb_xfer(1'b0, 8'h02, '0, rd, er);
    chk("misaligned_data", rd, '0);
    chk("misaligned_err", DW'(er), 32'h1);
    apb_xfer(1'b0, 8'h50, '0, rd, er);
    chk("unmapped_data", rd, '0);
    chk("unmapped_err", DW'(er), 32'h1);
    apb_xfer(1'b1, 8'h0C, 32'hFFFF_FFFF, rd, er);
    chk("id_write_err", DW'(er), 32'h1);
    apb_xfer(1'b0, 8'h0C, '0, rd, er);
    chk("id_unchanged", rd, 32'h0004_0010);
    apb_xfer(1'b1, 8'h00, 32'h8000_0000, rd, er);
    chk("pe_reset_pulse", DW'(pe_reset), 32'h1);
    chk("pe_reset_no_start", DW'(start), '0);

    done_req = 4'b0001;
    tick();
    tick();
    apb_xfer(1'b1, 8'h00, 32'hF, rd, er);
    chk("busy_all", DW'(busy), 32'hF);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 8'h10; apb.PWDATA = 32'hAAAA_5555;
    tick();
    apb.PENABLE = 1'b1;
    #2;
    PRESETn  = 1'b0;
    m_prdata = '0;
    #1;
    chk_all_zero("abort");
    tick();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    PRESETn = 1'b1;
    tick();
    apb_xfer(1'b0, 8'h10, '0, rd, er);
    chk("abort_no_write", rd, '0);
    chk("post_reset_err", DW'(er), '0);
    apb_xfer(1'b0, 8'h04, '0, rd, er);
    chk("reset_no_status", rd, '0);

    rand_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      wd = $urandom;
      case (op)
        0, 1, 2: apb_xfer(1'b1, AW'(16 + 4 * $urandom_range(0, NC - 1)), wd, rd, er);
        3:       apb_xfer(1'b0, AW'(16 + 4 * $urandom_range(0, NC - 1)), wd, rd, er);
        4: begin
          wd = wd & 32'hF;
          if ($urandom_range(0, 7) == 0) wd[DW-1] = 1'b1;
          apb_xfer(1'b1, 8'h00, wd, rd, er);
        end
        5:       apb_xfer(1'b0, AW'(4 * $urandom_range(0, 3)), wd, rd, er);
        6:       apb_xfer(1'b1, 8'h04, wd, rd, er);
        7:       apb_xfer(1'b1, 8'h08, wd, rd, er);
        8: begin
          a = AW'($urandom_range(0, 255));
          apb_xfer($urandom_range(0, 1) == 1, a, wd, rd, er);
        end
        default: repeat ($urandom_range(1, 3)) tick();
      endcase
    end
    rand_en = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
